// File: rtl/clock_ratio_detector_pkg.sv
// Shared constants for the divided-clock ratio detector.
package clock_ratio_detector_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    // Shortest period that still has both a high and a low phase.
    localparam int MIN_RATIO = 2;

endpackage

// File: rtl/clock_edge_sampler.sv
// Two-stage sampler of a reference-synchronous clock with a rising-edge strobe.
module clock_edge_sampler (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_din,
    output logic o_s0,
    output logic o_rise
);

    logic r_s0;
    logic r_s1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
        end else if (i_clr) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
        end else begin
            r_s0 <= i_din;
            r_s1 <= r_s0;
        end
    end

    assign o_s0   = r_s0;
    assign o_rise = r_s0 & ~r_s1;

endmodule

// File: rtl/clock_ratio_detector.sv
// Recovers period and high-phase length of a divided clock in reference cycles,
// locks after LOCK_CNT identical periods and flags loss of lock or a stopped clock.
module clock_ratio_detector
    import clock_ratio_detector_pkg::*;
#(
    parameter int RATIO_WIDTH = 3,
    parameter int LOCK_CNT    = 2
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic                   i_div_clk,
    output logic [RATIO_WIDTH-1:0] o_ratio,
    output logic [RATIO_WIDTH-1:0] o_high,
    output logic                   o_odd,
    output logic                   o_valid,
    output logic                   o_err,
    output logic                   o_timeout
);

    localparam int              CW       = RATIO_WIDTH + 1;
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(2**RATIO_WIDTH);
    localparam logic [CW-1:0]   P_MIN    = CW'(MIN_RATIO);
    localparam logic [CW-1:0]   P_MAX    = CW'(2**RATIO_WIDTH - 1);
    localparam logic [2:0]      LOCK_TGT = 3'(LOCK_CNT);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic          w_clr;
    logic          w_s0;
    logic          w_rise;
    logic          w_per_ok;
    logic          w_ref_eq;
    logic          w_lock_eq;
    logic          w_cnt_sat;
    logic [2:0]    w_match_nxt;

    logic [CW-1:0]          r_p_cnt;
    logic [CW-1:0]          r_h_cnt;
    logic [1:0]             r_state;
    logic [2:0]             r_match;
    logic [CW-1:0]          r_ref_p;
    logic [CW-1:0]          r_ref_h;
    logic [RATIO_WIDTH-1:0] r_ratio;
    logic [RATIO_WIDTH-1:0] r_high;
    logic                   r_valid;
    logic                   r_err;
    logic                   r_timeout;

    assign w_clr = ~i_en;

    clock_edge_sampler u_sampler (
        .i_clk  (i_ref_clk),
        .i_rst  (i_rst_n),
        .i_clr  (w_clr),
        .i_din  (i_div_clk),
        .o_s0   (w_s0),
        .o_rise (w_rise)
    );

    // Counter values seen together with a rise are the just-finished period.
    always_ff @(posedge i_ref_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            r_p_cnt <= '0;
            r_h_cnt <= '0;
        end else if (!i_en) begin
            r_p_cnt <= '0;
            r_h_cnt <= '0;
        end else if (w_rise) begin
            r_p_cnt <= CNT_ONE;
            r_h_cnt <= CNT_ONE;
        end else begin
            r_p_cnt <= sat_inc(r_p_cnt);
            if (w_s0) begin
                r_h_cnt <= sat_inc(r_h_cnt);
            end
        end
    end

    assign w_per_ok    = (r_p_cnt >= P_MIN) && (r_p_cnt <= P_MAX);
    assign w_ref_eq    = (r_p_cnt == r_ref_p) && (r_h_cnt == r_ref_h);
    assign w_lock_eq   = (r_p_cnt == {1'b0, r_ratio}) && (r_h_cnt == {1'b0, r_high});
    assign w_cnt_sat   = (r_p_cnt == CNT_MAX);
    assign w_match_nxt = !w_ref_eq ? 3'd1 : ((r_match == 3'd7) ? 3'd7 : r_match + 3'd1);

    always_ff @(posedge i_ref_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            r_state   <= IDLE;
            r_match   <= '0;
            r_ref_p   <= '0;
            r_ref_h   <= '0;
            r_ratio   <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else if (!i_en) begin
            r_state   <= IDLE;
            r_match   <= '0;
            r_ref_p   <= '0;
            r_ref_h   <= '0;
            r_ratio   <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    // First rise only opens a period; nothing is measured yet.
                    if (w_rise) begin
                        r_state   <= MEASURE;
                        r_match   <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (w_rise) begin
                        if (w_per_ok) begin
                            r_ref_p <= r_p_cnt;
                            r_ref_h <= r_h_cnt;
                            r_match <= w_match_nxt;
                            if (w_match_nxt >= LOCK_TGT) begin
                                r_state <= LOCKED;
                                r_ratio <= r_p_cnt[RATIO_WIDTH-1:0];
                                r_high  <= r_h_cnt[RATIO_WIDTH-1:0];
                                r_valid <= 1'b1;
                            end
                        end else begin
                            r_match <= '0;
                        end
                    end else if (w_cnt_sat) begin
                        r_state   <= IDLE;
                        r_timeout <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (w_rise) begin
                        if (!w_lock_eq) begin
                            r_err   <= 1'b1;
                            r_valid <= 1'b0;
                            r_state <= MEASURE;
                            if (w_per_ok) begin
                                r_ref_p <= r_p_cnt;
                                r_ref_h <= r_h_cnt;
                                r_match <= 3'd1;
                            end else begin
                                r_match <= '0;
                            end
                        end
                    end else if (w_cnt_sat) begin
                        r_state   <= IDLE;
                        r_timeout <= 1'b1;
                        r_valid   <= 1'b0;
                        r_err     <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ratio   = r_ratio;
    assign o_high    = r_high;
    assign o_odd     = r_ratio[0];
    assign o_valid   = r_valid;
    assign o_err     = r_err;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_clock_ratio_detector.sv
// Randomized bench for clock_ratio_detector with a period/duty reference model.
module tb_clock_ratio_detector;

    localparam int RW   = 3;
    localparam int LK   = 2;
    localparam int CMAX = 8;

    logic          clk = 1'b0;
    logic          i_rst_n;
    logic          i_en;
    logic          i_div_clk;
    logic [RW-1:0] o_ratio;
    logic [RW-1:0] o_high;
    logic          o_odd;
    logic          o_valid;
    logic          o_err;
    logic          o_timeout;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b1;

    // divider generator controls
    int div_n   = 4;
    int div_h   = 2;
    int div_ph  = 0;
    bit div_run = 1'b0;

    // reference model state
    int         m_state, m_a, m_rp, m_rh, m_match, cyc;
    logic [2:0] m_ratio, m_high;
    bit         m_valid, m_err, m_tmo;
    bit         smp1, smp2;
    bit         s0_log [65536];

    clock_ratio_detector #(.RATIO_WIDTH(RW), .LOCK_CNT(LK)) dut (
        .i_ref_clk (clk),
        .i_rst_n   (i_rst_n),
        .i_en      (i_en),
        .i_div_clk (i_div_clk),
        .o_ratio   (o_ratio),
        .o_high    (o_high),
        .o_odd     (o_odd),
        .o_valid   (o_valid),
        .o_err     (o_err),
        .o_timeout (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs_vec();
        return {22'd0, o_ratio, o_high, o_odd, o_valid, o_err, o_timeout};
    endfunction

    function automatic logic [31:0] exp_vec();
        return {22'd0, m_ratio, m_high, m_ratio[0], m_valid, m_err, m_tmo};
    endfunction

    function automatic int pick_h(input int n);
        if (n % 2 == 1) return (n / 2) + int'($urandom_range(0, 1));
        return n / 2;
    endfunction

    initial begin
        i_div_clk = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (div_run) begin
                div_ph    = (div_ph + 1) % div_n;
                i_div_clk = (div_ph < div_h);
            end else begin
                i_div_clk = 1'b0;
            end
        end
    end

    // Periods are rise-to-rise distances on the sampled stream; high is the
    // number of sampled ones inside that window.
    always @(posedge clk or posedge i_rst_n) begin
        if (i_rst_n || !i_en) begin
            m_state = 0; m_match = 0; m_rp = 0; m_rh = 0;
            m_ratio = '0; m_high = '0;
            m_valid = 0; m_err = 0; m_tmo = 0;
            smp1 = 0; smp2 = 0;
            cyc++;
        end else begin
            bit s0, rise, per_ok;
            int p, h;
            s0   = smp1;
            rise = smp1 && !smp2;
            s0_log[cyc % 65536] = s0;
            p = cyc - m_a;
            if (p > CMAX) p = CMAX;
            h = 0;
            for (int k = m_a; k < cyc && k <= m_a + CMAX; k++) h += int'(s0_log[k % 65536]);
            if (h > CMAX) h = CMAX;
            per_ok = (p >= 2) && (p <= CMAX - 1);
            m_err = 0;
            case (m_state)
                0: if (rise) begin
                    m_state = 1; m_tmo = 0; m_match = 0; m_a = cyc;
                end
                1: if (rise) begin
                    if (per_ok) begin
                        if (p == m_rp && h == m_rh) m_match++;
                        else begin m_rp = p; m_rh = h; m_match = 1; end
                        if (m_match >= LK) begin
                            m_state = 2; m_ratio = p[2:0]; m_high = h[2:0]; m_valid = 1;
                        end
                    end else m_match = 0;
                    m_a = cyc;
                end else if (p >= CMAX) begin
                    m_state = 0; m_tmo = 1;
                end
                default: if (rise) begin
                    if (p != int'(m_ratio) || h != int'(m_high)) begin
                        m_err = 1; m_valid = 0; m_state = 1;
                        if (per_ok) begin m_rp = p; m_rh = h; m_match = 1; end
                        else m_match = 0;
                    end
                    m_a = cyc;
                end else if (p >= CMAX) begin
                    m_state = 0; m_tmo = 1; m_valid = 0; m_err = 1;
                end
            endcase
            smp2 = smp1;
            smp1 = i_div_clk;
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_on) chk("cycle_outputs", obs_vec(), exp_vec());
    end

    task automatic wait_sig(input int which, input logic lvl, input int budget, input string tag);
        int   n = 0;
        logic seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            case (which)
                0:       seen = (o_valid === lvl);
                1:       seen = (o_err === lvl);
                default: seen = (o_timeout === lvl);
            endcase
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic restart(input int n, input int h);
        @(posedge clk);
        #2;
        i_en    = 1'b0;
        div_n   = n;
        div_h   = h;
        div_ph  = int'($urandom_range(0, n - 1));
        div_run = 1'b1;
        @(posedge clk);
        #2;
        i_en = 1'b1;
    endtask

    initial begin
        i_rst_n = 1'b1;
        i_en    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", obs_vec(), 32'd0);
        @(posedge clk);
        #3;
        i_rst_n = 1'b0;

        restart(4, 2);
        wait_sig(0, 1'b1, 60, "r4_lock");
        chk("r4_ratio", o_ratio, 4);
        chk("r4_high", o_high, 2);
        chk("r4_odd", o_odd, 0);
        repeat (30) @(posedge clk);

        restart(5, pick_h(5));
        wait_sig(0, 1'b1, 60, "r5_lock");
        chk("r5_ratio", o_ratio, 5);
        chk("r5_high_2_or_3", {31'd0, (o_high == 3'd2 || o_high == 3'd3)}, 1);
        chk("r5_odd", o_odd, 1);

        restart(7, pick_h(7));
        wait_sig(0, 1'b1, 80, "r7_lock");
        chk("r7_ratio", o_ratio, 7);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("r7_no_timeout", o_timeout, 0);

        restart(4, 2);
        wait_sig(0, 1'b1, 60, "r46_lock4");
        @(posedge clk);
        #2;
        div_n = 6;
        div_h = 3;
        wait_sig(1, 1'b1, 40, "r46_err");
        chk("r46_valid_at_err", o_valid, 0);
        wait_sig(0, 1'b1, 40, "r46_relock");
        chk("r46_ratio", o_ratio, 6);
        chk("r46_high", o_high, 3);

        restart(3, pick_h(3));
        wait_sig(0, 1'b1, 60, "to_lock3");
        @(posedge clk);
        #2;
        div_run = 1'b0;
        wait_sig(2, 1'b1, 20, "to_timeout");
        chk("to_err", o_err, 1);
        chk("to_valid", o_valid, 0);
        repeat (5) @(posedge clk);
        #2;
        div_ph  = div_n - 1;
        div_run = 1'b1;
        wait_sig(2, 1'b0, 20, "to_clear");
        wait_sig(0, 1'b1, 40, "to_relock");
        chk("to_ratio", o_ratio, 3);

        restart(6, 3);
        wait_sig(0, 1'b1, 60, "rst_lock6");
        @(posedge clk);
        #3;
        i_rst_n = 1'b1;
        #1;
        chk("rst_async_zero", obs_vec(), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        i_rst_n = 1'b0;
        wait_sig(0, 1'b1, 60, "rst_relock");
        chk("rst_ratio", o_ratio, 6);

        @(posedge clk);
        #2;
        i_en = 1'b0;
        @(negedge clk);
        chk("en_sync_hold", o_valid, 1);
        @(negedge clk);
        chk("en_cleared", obs_vec(), 32'd0);
        @(posedge clk);
        #2;
        i_en = 1'b1;
        wait_sig(0, 1'b1, 60, "en_relock");
        chk("en_ratio", o_ratio, 6);

        for (int it = 0; it < 60; it++) begin
            int sel;
            int n;
            sel = int'($urandom_range(0, 9));
            @(posedge clk);
            #2;
            if (sel == 0) begin
                i_en = 1'b0;
                @(posedge clk);
                #2;
                i_en = 1'b1;
            end else if (sel == 1) begin
                div_run = 1'b0;
            end else if (sel == 2) begin
                n       = int'($urandom_range(8, 9));
                div_n   = n;
                div_h   = n / 2;
                div_run = 1'b1;
            end else begin
                n       = int'($urandom_range(2, 7));
                div_n   = n;
                div_h   = pick_h(n);
                div_run = 1'b1;
            end
            repeat ($urandom_range(10, 60)) @(posedge clk);
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/clock_ratio_detector.md
Name: clock_ratio_detector

Overview:
Measures a divided clock and recovers its division ratio and high-phase length in reference clock cycles. The divided clock is produced elsewhere from the same reference clock. The block sits beside the clock divider as its checker and observer. Status outputs are used by the control/self-test logic to confirm the programmed ratio, detect ratio changes and detect a stopped clock.

Parameters:
RATIO_WIDTH, 3, width of the reported ratio; maximum measurable ratio is 2^RATIO_WIDTH-1.
LOCK_CNT, 2, number of consecutive identical periods required to declare lock (1..7).

Ports:
i_ref_clk  input  1  reference clock; the only clock in the block.
i_rst_n  input  1  asynchronous, active-high reset (1 = reset).
i_en  input  1  detector enable; 0 clears all state and outputs synchronously.
i_div_clk  input  1  divided clock under measurement, synchronous to i_ref_clk.
o_ratio  output  RATIO_WIDTH  locked period in i_ref_clk cycles.
o_high  output  RATIO_WIDTH  locked high-phase length in i_ref_clk cycles.
o_odd  output  1  equals o_ratio[0]; qualified by o_valid.
o_valid  output  1  1 while in LOCKED.
o_err  output  1  one-cycle pulse on loss of lock (mismatch or timeout).
o_timeout  output  1  level; 1 from a timeout until the next rising edge of i_div_clk.

Behaviour:
- Reset (async) and i_en=0 (sync) have the same effect:
  - all outputs are 0;
  - counters, s0 and s1 are cleared;
  - state is IDLE.
- Sampling:
  - s0 registers i_div_clk; s1 registers s0.
  - rise = s0 & ~s1. Only rises delimit periods.
- Counters, each RATIO_WIDTH+1 bits:
  - p_cnt loads 1 on a rise, otherwise increments.
  - h_cnt loads 1 on a rise, otherwise increments when s0=1.
  - Both saturate at 2^RATIO_WIDTH.
- Measurement:
  - On a rise, meas_p = p_cnt and meas_h = h_cnt, using register values before the reload.
  - For ratio N, meas_p = N.
- Period validity: a period is valid when 2 <= meas_p <= 2^RATIO_WIDTH-1.
- Matching:
  - match_cnt (3 bits) counts consecutive valid periods equal to ref_p/ref_h.
  - ref_p and ref_h are held internally.
- States:
  - IDLE: wait for the first rise, then go to MEASURE. There is no measurement on this rise (period unknown). Clear o_timeout.
  - MEASURE: on each rise with a valid period:
    - If it equals ref, increment match_cnt.
    - Otherwise set ref to the new value and set match_cnt=1.
    - When match_cnt reaches LOCK_CNT, go to LOCKED. In the same cycle, load o_ratio=ref_p and o_high=ref_h, and set o_valid=1.
    - Invalid period: set match_cnt=0 and stay in MEASURE.
  - LOCKED:
    - A rise with meas_p/meas_h equal to o_ratio/o_high keeps the lock.
    - A rise with any difference:
      - o_err pulses for 1 cycle and o_valid goes 0.
      - The state goes to MEASURE with ref = new measurement and match_cnt=1, if that measurement is valid.
      - o_ratio and o_high hold their last locked values.
- Timeout, in any state except IDLE:
  - Triggered when p_cnt reaches 2^RATIO_WIDTH without a rise.
  - o_timeout=1 and o_valid=0.
  - o_err pulses once only if the state was LOCKED.
  - The state goes to IDLE.
- Lock latency: with a stable ratio, o_valid rises in the cycle after the (LOCK_CNT+1)-th rise after enable. The first rise only starts the measurement.
- Simultaneous events:
  - A rise takes priority over timeout; the counter reload happens first.
  - i_en=0 overrides everything.
- Reset mid-operation: outputs drop immediately (async). After release, re-acquisition starts from IDLE.
- Duty: for odd N, o_high is either N>>1 or (N>>1)+1, depending on divider phase. Both are accepted; lock requires consistency only.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=2'd0, MEASURE=2'd1, LOCKED=2'd2;
  - the MIN_RATIO=2 constant.
- The optional sub-module is clock_edge_sampler (s0/s1 registers plus rise output), reusable by other clock monitors.
- Everything else stays in one module.

Test Plan:
- Divider at ratio 4, i_en=1 -> o_valid=1 after the third rise; o_ratio=4, o_high=2, o_odd=0, o_err never 1.
- Ratio 5 -> o_ratio=5, o_high in {2,3}, o_odd=1.
- Ratio 7 (maximum) -> lock with o_ratio=7; no timeout.
- Locked at 4, divider reprogrammed to 6:
  - one o_err pulse and o_valid=0 at the first mismatched rise;
  - relock to o_ratio=6 after LOCK_CNT-1 further equal periods.
- Locked at 3, i_div_clk held low:
  - o_timeout=1, o_err pulse and o_valid=0 once p_cnt hits 8;
  - restart the clock at ratio 3 -> o_timeout clears on the first rise, and lock follows.
- Locked at 6:
  - assert i_rst_n mid-period -> all outputs 0 asynchronously; release -> relock at 6.
  - Repeat with i_en=0 for 1 cycle -> same result, applied synchronously.
